// File: rtl/riscv_constants.sv
// Shared RISC-V constants: ALU/branch function codes and the arbiter state type.
package riscv_constants;

    localparam int unsigned ALU_FUNC_W = 4;
    localparam int unsigned BR_FUNC_W  = 3;

    localparam logic [ALU_FUNC_W-1:0] ALU_ADD  = 4'h0;
    localparam logic [ALU_FUNC_W-1:0] ALU_SUB  = 4'h1;
    localparam logic [ALU_FUNC_W-1:0] ALU_SLL  = 4'h2;
    localparam logic [ALU_FUNC_W-1:0] ALU_SLT  = 4'h3;
    localparam logic [ALU_FUNC_W-1:0] ALU_SLTU = 4'h4;
    localparam logic [ALU_FUNC_W-1:0] ALU_XOR  = 4'h5;
    localparam logic [ALU_FUNC_W-1:0] ALU_SRL  = 4'h6;
    localparam logic [ALU_FUNC_W-1:0] ALU_SRA  = 4'h7;
    localparam logic [ALU_FUNC_W-1:0] ALU_OR   = 4'h8;
    localparam logic [ALU_FUNC_W-1:0] ALU_AND  = 4'h9;

    // Branch codes follow the RISC-V funct3 encoding; 2 and 3 are unused.
    localparam logic [BR_FUNC_W-1:0] BR_EQ  = 3'd0;
    localparam logic [BR_FUNC_W-1:0] BR_NE  = 3'd1;
    localparam logic [BR_FUNC_W-1:0] BR_LT  = 3'd4;
    localparam logic [BR_FUNC_W-1:0] BR_GE  = 3'd5;
    localparam logic [BR_FUNC_W-1:0] BR_LTU = 3'd6;
    localparam logic [BR_FUNC_W-1:0] BR_GEU = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } alu_arb_state_t;

endpackage

// File: rtl/riscv_alu.sv
// Combinational RV32 integer ALU with branch comparator.
module riscv_alu
    import riscv_constants::*;
(
    input  logic [ALU_FUNC_W-1:0] alu_func_in,
    input  logic [BR_FUNC_W-1:0]  br_func_in,
    input  logic [31:0]           a_in,
    input  logic [31:0]           b_in,
    output logic [31:0]           result_out,
    output logic                  branch_taken_out
);

    // Arithmetic/logic result; unknown codes yield zero.
    always_comb begin
        result_out = '0;
        case (alu_func_in)
            ALU_ADD:  result_out = a_in + b_in;
            ALU_SUB:  result_out = a_in - b_in;
            ALU_SLL:  result_out = a_in << b_in[4:0];
            ALU_SLT:  result_out = {31'b0, $signed(a_in) < $signed(b_in)};
            ALU_SLTU: result_out = {31'b0, a_in < b_in};
            ALU_XOR:  result_out = a_in ^ b_in;
            ALU_SRL:  result_out = a_in >> b_in[4:0];
            ALU_SRA:  result_out = $unsigned($signed(a_in) >>> b_in[4:0]);
            ALU_OR:   result_out = a_in | b_in;
            ALU_AND:  result_out = a_in & b_in;
            default:  result_out = '0;
        endcase
    end

    // Branch condition; unknown codes never take.
    always_comb begin
        branch_taken_out = 1'b0;
        case (br_func_in)
            BR_EQ:   branch_taken_out = (a_in == b_in);
            BR_NE:   branch_taken_out = (a_in != b_in);
            BR_LT:   branch_taken_out = ($signed(a_in) < $signed(b_in));
            BR_GE:   branch_taken_out = ($signed(a_in) >= $signed(b_in));
            BR_LTU:  branch_taken_out = (a_in < b_in);
            BR_GEU:  branch_taken_out = (a_in >= b_in);
            default: branch_taken_out = 1'b0;
        endcase
    end

endmodule

// File: rtl/riscv_alu_arbiter.sv
// Two-requester round-robin arbiter sharing one riscv_alu (IDLE -> EXEC -> RESP).
module riscv_alu_arbiter
    import riscv_constants::*;
#(
    parameter int unsigned TAG_W = 4
)
(
    input  logic                  clk_in,
    input  logic                  rst_n_in,

    input  logic                  req0_valid_in,
    output logic                  req0_ready_out,
    input  logic [ALU_FUNC_W-1:0] req0_alu_func_in,
    input  logic [BR_FUNC_W-1:0]  req0_br_func_in,
    input  logic [31:0]           req0_a_in,
    input  logic [31:0]           req0_b_in,
    input  logic [TAG_W-1:0]      req0_tag_in,

    input  logic                  req1_valid_in,
    output logic                  req1_ready_out,
    input  logic [ALU_FUNC_W-1:0] req1_alu_func_in,
    input  logic [BR_FUNC_W-1:0]  req1_br_func_in,
    input  logic [31:0]           req1_a_in,
    input  logic [31:0]           req1_b_in,
    input  logic [TAG_W-1:0]      req1_tag_in,

    output logic                  rsp0_valid_out,
    input  logic                  rsp0_ready_in,
    output logic [31:0]           rsp0_result_out,
    output logic                  rsp0_branch_taken_out,
    output logic [TAG_W-1:0]      rsp0_tag_out,

    output logic                  rsp1_valid_out,
    input  logic                  rsp1_ready_in,
    output logic [31:0]           rsp1_result_out,
    output logic                  rsp1_branch_taken_out,
    output logic [TAG_W-1:0]      rsp1_tag_out,

    output logic [15:0]           op_count_out
);

    alu_arb_state_t          state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic                    owner_q, owner_d;
    logic [ALU_FUNC_W-1:0]   op_func_q, op_func_d;
    logic [BR_FUNC_W-1:0]    op_br_q, op_br_d;
    logic [31:0]             op_a_q, op_a_d;
    logic [31:0]             op_b_q, op_b_d;
    logic [TAG_W-1:0]        op_tag_q, op_tag_d;
    logic [31:0]             rsp_result_q, rsp_result_d;
    logic                    rsp_taken_q, rsp_taken_d;
    logic [TAG_W-1:0]        rsp_tag_q, rsp_tag_d;
    logic [15:0]             op_count_q, op_count_d;

    logic                    grant0, grant1;
    logic                    ready0_c, ready1_c;
    logic [31:0]             alu_result;
    logic                    alu_taken;

    // The ALU only ever sees the latched operands.
    riscv_alu u_alu (
        .alu_func_in      (op_func_q),
        .br_func_in       (op_br_q),
        .a_in             (op_a_q),
        .b_in             (op_b_q),
        .result_out       (alu_result),
        .branch_taken_out (alu_taken)
    );

    // On contention the requester that did not win last time is granted.
    assign grant0 = req0_valid_in && (!req1_valid_in || (last_grant_q != 1'b0));
    assign grant1 = req1_valid_in && (!req0_valid_in || (last_grant_q != 1'b1));

    // Next-state, operand/response capture and ready generation.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        op_func_d    = op_func_q;
        op_br_d      = op_br_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_tag_d     = op_tag_q;
        rsp_result_d = rsp_result_q;
        rsp_taken_d  = rsp_taken_q;
        rsp_tag_d    = rsp_tag_q;
        op_count_d   = op_count_q;
        ready0_c     = 1'b0;
        ready1_c     = 1'b0;
        case (state_q)
            IDLE: begin
                ready0_c = grant0;
                ready1_c = grant1;
                if (grant0 || grant1) begin
                    owner_d      = grant1;
                    last_grant_d = grant1;
                    op_func_d    = grant1 ? req1_alu_func_in : req0_alu_func_in;
                    op_br_d      = grant1 ? req1_br_func_in  : req0_br_func_in;
                    op_a_d       = grant1 ? req1_a_in        : req0_a_in;
                    op_b_d       = grant1 ? req1_b_in        : req0_b_in;
                    op_tag_d     = grant1 ? req1_tag_in      : req0_tag_in;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d = alu_result;
                rsp_taken_d  = alu_taken;
                rsp_tag_d    = op_tag_q;
                state_d      = RESP;
            end
            RESP: begin
                if (owner_q ? rsp1_ready_in : rsp0_ready_in) begin
                    op_count_d = op_count_q + 16'd1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            op_func_q    <= '0;
            op_br_q      <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_tag_q     <= '0;
            rsp_result_q <= '0;
            rsp_taken_q  <= 1'b0;
            rsp_tag_q    <= '0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            op_func_q    <= op_func_d;
            op_br_q      <= op_br_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_tag_q     <= op_tag_d;
            rsp_result_q <= rsp_result_d;
            rsp_taken_q  <= rsp_taken_d;
            rsp_tag_q    <= rsp_tag_d;
            op_count_q   <= op_count_d;
        end
    end

    // Readies are masked by reset since IDLE grants are purely combinational.
    assign req0_ready_out = ready0_c && rst_n_in;
    assign req1_ready_out = ready1_c && rst_n_in;

    assign rsp0_valid_out        = (state_q == RESP) && (owner_q == 1'b0);
    assign rsp1_valid_out        = (state_q == RESP) && (owner_q == 1'b1);
    assign rsp0_result_out       = rsp0_valid_out ? rsp_result_q : '0;
    assign rsp0_branch_taken_out = rsp0_valid_out && rsp_taken_q;
    assign rsp0_tag_out          = rsp0_valid_out ? rsp_tag_q : '0;
    assign rsp1_result_out       = rsp1_valid_out ? rsp_result_q : '0;
    assign rsp1_branch_taken_out = rsp1_valid_out && rsp_taken_q;
    assign rsp1_tag_out          = rsp1_valid_out ? rsp_tag_q : '0;

    assign op_count_out = op_count_q;

endmodule

// File: tb/tb_riscv_alu_arbiter.sv
// Directed self-checking bench for riscv_alu_arbiter.
module tb_riscv_alu_arbiter;
    import riscv_constants::*;

    localparam int unsigned TAG_W = 4;

    logic              clk;
    logic              rst_n;
    logic              req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]        req0_func, req1_func;
    logic [2:0]        req0_br, req1_br;
    logic [31:0]       req0_a, req0_b, req1_a, req1_b;
    logic [TAG_W-1:0]  req0_tag, req1_tag;
    logic              rsp0_valid, rsp0_ready, rsp0_taken;
    logic              rsp1_valid, rsp1_ready, rsp1_taken;
    logic [31:0]       rsp0_result, rsp1_result;
    logic [TAG_W-1:0]  rsp0_tag, rsp1_tag;
    logic [15:0]       op_count;

    int vectors = 0;
    int miscompares = 0;

    riscv_alu_arbiter #(.TAG_W(TAG_W)) dut (
        .clk_in                (clk),
        .rst_n_in              (rst_n),
        .req0_valid_in         (req0_valid),
        .req0_ready_out        (req0_ready),
        .req0_alu_func_in      (req0_func),
        .req0_br_func_in       (req0_br),
        .req0_a_in             (req0_a),
        .req0_b_in             (req0_b),
        .req0_tag_in           (req0_tag),
        .req1_valid_in         (req1_valid),
        .req1_ready_out        (req1_ready),
        .req1_alu_func_in      (req1_func),
        .req1_br_func_in       (req1_br),
        .req1_a_in             (req1_a),
        .req1_b_in             (req1_b),
        .req1_tag_in           (req1_tag),
        .rsp0_valid_out        (rsp0_valid),
        .rsp0_ready_in         (rsp0_ready),
        .rsp0_result_out       (rsp0_result),
        .rsp0_branch_taken_out (rsp0_taken),
        .rsp0_tag_out          (rsp0_tag),
        .rsp1_valid_out        (rsp1_valid),
        .rsp1_ready_in         (rsp1_ready),
        .rsp1_result_out       (rsp1_result),
        .rsp1_branch_taken_out (rsp1_taken),
        .rsp1_tag_out          (rsp1_tag),
        .op_count_out          (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive0(input logic v, input logic [3:0] f, input logic [2:0] br,
                          input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
        req0_valid = v; req0_func = f; req0_br = br; req0_a = a; req0_b = b; req0_tag = t;
    endtask

    task automatic drive1(input logic v, input logic [3:0] f, input logic [2:0] br,
                          input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
        req1_valid = v; req1_func = f; req1_br = br; req1_a = a; req1_b = b; req1_tag = t;
    endtask

    initial begin
        rst_n = 1'b1;
        drive0(1'b1, ALU_ADD, BR_EQ, 32'd0, 32'd0, '0);
        drive1(1'b0, ALU_ADD, BR_EQ, 32'd0, 32'd0, '0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        #1 rst_n = 1'b0;

        // Reset: outputs quiet even with a request pending
        @(negedge clk);
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_rsp0_valid", rsp0_valid, 0);
        check("rst_rsp1_valid", rsp1_valid, 0);
        check("rst_op_count", op_count, 0);
        check("rst_rsp0_result", rsp0_result, 0);
        req0_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Single ADD on requester 0
        drive0(1'b1, ALU_ADD, BR_EQ, 32'd5, 32'd7, 4'd3);
        rsp0_ready = 1'b1;
        #1;
        check("t1_req0_ready", req0_ready, 1);
        check("t1_req1_ready", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        #1;
        check("t1_exec_rsp0_valid", rsp0_valid, 0);
        check("t1_exec_req0_ready", req0_ready, 0);
        tick();
        check("t1_rsp0_valid", rsp0_valid, 1);
        check("t1_rsp0_result", rsp0_result, 32'd12);
        check("t1_rsp0_tag", rsp0_tag, 3);
        check("t1_rsp0_taken", rsp0_taken, 0);
        check("t1_rsp1_valid", rsp1_valid, 0);
        tick();
        check("t1_done_rsp0_valid", rsp0_valid, 0);
        check("t1_op_count", op_count, 1);

        // Contention right after reset: 0 first, then 1
        rst_n = 1'b0;
        #1;
        check("t2_rst_op_count", op_count, 0);
        tick();
        rst_n = 1'b1;
        drive0(1'b1, ALU_ADD, BR_EQ, 32'd1, 32'd2, 4'd1);
        drive1(1'b1, ALU_SUB, BR_EQ, 32'd10, 32'd4, 4'd2);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        #1;
        check("t2_req0_ready", req0_ready, 1);
        check("t2_req1_ready", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        tick();
        check("t2_rsp0_valid", rsp0_valid, 1);
        check("t2_rsp0_result", rsp0_result, 32'd3);
        check("t2_rsp1_valid_a", rsp1_valid, 0);
        check("t2_rsp1_result_a", rsp1_result, 0);
        tick();
        check("t2_req1_ready", req1_ready, 1);
        check("t2_req0_ready_b", req0_ready, 0);
        tick();
        req1_valid = 1'b0;
        tick();
        check("t2_rsp1_valid", rsp1_valid, 1);
        check("t2_rsp1_result", rsp1_result, 32'd6);
        check("t2_rsp1_tag", rsp1_tag, 2);
        check("t2_rsp0_valid_b", rsp0_valid, 0);
        check("t2_rsp0_result_b", rsp0_result, 0);
        check("t2_rsp0_tag_b", rsp0_tag, 0);
        tick();
        check("t2_op_count", op_count, 2);

        // Both continuously valid: grants alternate 0,1,0,1,0,1
        for (int i = 0; i < 6; i++) begin
            drive0(1'b1, ALU_ADD, BR_EQ, 32'd100, 32'(i), 4'(i));
            drive1(1'b1, ALU_SUB, BR_EQ, 32'd50, 32'(i), 4'(i + 8));
            #1;
            check($sformatf("t3_req0_ready_%0d", i), req0_ready, (i % 2 == 0) ? 1 : 0);
            check($sformatf("t3_req1_ready_%0d", i), req1_ready, (i % 2 == 1) ? 1 : 0);
            tick();
            tick();
            if (i % 2 == 0) begin
                check($sformatf("t3_rsp0_valid_%0d", i), rsp0_valid, 1);
                check($sformatf("t3_rsp0_result_%0d", i), rsp0_result, 32'(100 + i));
                check($sformatf("t3_rsp1_valid_%0d", i), rsp1_valid, 0);
            end else begin
                check($sformatf("t3_rsp1_valid_%0d", i), rsp1_valid, 1);
                check($sformatf("t3_rsp1_result_%0d", i), rsp1_result, 32'(50 - i));
                check($sformatf("t3_rsp1_tag_%0d", i), rsp1_tag, 32'(i + 8));
                check($sformatf("t3_rsp0_valid_%0d", i), rsp0_valid, 0);
            end
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        check("t3_op_count", op_count, 8);

        // Response back-pressure on port 1 for 5 cycles
        drive1(1'b1, ALU_XOR, BR_NE, 32'hF0F0_0000, 32'h0FF0_1234, 4'd5);
        rsp1_ready = 1'b0;
        #1;
        check("t4_req1_ready", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        drive0(1'b1, ALU_ADD, BR_EQ, 32'd0, 32'd0, 4'd0);
        rsp0_ready = 1'b1;
        tick();
        for (int c = 0; c < 5; c++) begin
            check($sformatf("t4_rsp1_valid_%0d", c), rsp1_valid, 1);
            check($sformatf("t4_rsp1_result_%0d", c), rsp1_result, 32'hFF00_1234);
            check($sformatf("t4_rsp1_taken_%0d", c), rsp1_taken, 1);
            check($sformatf("t4_rsp1_tag_%0d", c), rsp1_tag, 5);
            check($sformatf("t4_req0_ready_%0d", c), req0_ready, 0);
            check($sformatf("t4_req1_ready_%0d", c), req1_ready, 0);
            check($sformatf("t4_rsp0_valid_%0d", c), rsp0_valid, 0);
            tick();
        end
        rsp1_ready = 1'b1;
        #1;
        check("t4_rsp1_valid_release", rsp1_valid, 1);
        tick();
        check("t4_rsp1_valid_idle", rsp1_valid, 0);
        check("t4_op_count", op_count, 9);
        check("t4_req0_ready_idle", req0_ready, 1);
        req0_valid = 1'b0;
        rsp1_ready = 1'b0;
        #1;
        check("t4_req0_ready_dropped", req0_ready, 0);
        tick();
        check("t4_drop_op_count", op_count, 9);
        check("t4_drop_req0_ready", req0_ready, 0);
        tick();
        check("t4_drop_rsp0_valid", rsp0_valid, 0);

        // Reset in EXEC discards the operation
        drive0(1'b1, ALU_ADD, BR_EQ, 32'd1, 32'd1, 4'd7);
        rsp0_ready = 1'b1;
        #1;
        check("t5_req0_ready", req0_ready, 1);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_req0_ready", req0_ready, 0);
        check("t5_rst_req1_ready", req1_ready, 0);
        check("t5_rst_rsp0_valid", rsp0_valid, 0);
        check("t5_rst_rsp1_valid", rsp1_valid, 0);
        check("t5_rst_op_count", op_count, 0);
        @(negedge clk);
        req0_valid = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("t5_no_rsp0_%0d", c), rsp0_valid, 0);
            check($sformatf("t5_no_count_%0d", c), op_count, 0);
        end
        drive1(1'b1, ALU_ADD, BR_EQ, 32'd20, 32'd22, 4'd9);
        rsp1_ready = 1'b1;
        #1;
        check("t5_req1_ready", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        tick();
        check("t5_rsp1_valid", rsp1_valid, 1);
        check("t5_rsp1_result", rsp1_result, 32'd42);
        check("t5_rsp1_tag", rsp1_tag, 9);
        tick();
        check("t5_op_count", op_count, 1);

        // Operation counter wrap from 16'hFFFF
        force dut.op_count_q = 16'hFFFF;
        @(posedge clk);
        #1 release dut.op_count_q;
        @(negedge clk);
        check("t6_preload", op_count, 32'hFFFF);
        drive0(1'b1, ALU_ADD, BR_LT, 32'hFFFF_FFFF, 32'd1, 4'd4);
        rsp0_ready = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick();
        check("t6_rsp0_result", rsp0_result, 0);
        check("t6_rsp0_taken", rsp0_taken, 1);
        tick();
        check("t6_op_count_wrap", op_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
